cascade_compare_ctrl: RTL and testbench

CASCADE_COMPARE_CTRL -- requirements
Module: cascade_compare_ctrl

---
 rtl/cascade_compare_ctrl.sv | 117 +++++++++++
 tb/tb_cascade_compare_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cascade_compare_ctrl.sv
// Byte-serial magnitude comparator, MS byte first, with handshake control.
// Define SIGNED_CMP_EN to compare the first byte as two's complement.
module cascade_compare_ctrl #(
  parameter int MAX_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_bytes,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       busy,
  output logic       done,
  output logic       LTout,
  output logic       EQout,
  output logic       GTout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] MAXB = 4'(MAX_BYTES);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] nb_sat;
  logic       acc;
  logic       load;
  logic       a_lt;
  logic       a_gt;

`ifdef SIGNED_CMP_EN
  logic first;
`endif

  assign nb_sat = (num_bytes > MAXB) ? MAXB : num_bytes;
  assign load   = (state == IDLE) && start;
  assign acc    = (state == RUN) && in_valid;

  always_comb begin
    a_lt = a_byte < b_byte;
    a_gt = a_byte > b_byte;
`ifdef SIGNED_CMP_EN
    if (first) begin
      a_lt = $signed(a_byte) < $signed(b_byte);
      a_gt = $signed(a_byte) > $signed(b_byte);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (num_bytes == 4'd0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc && cnt == 4'd1)
          state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Once a more-significant byte has decided, later bytes only count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      LTout <= 1'b0;
      EQout <= 1'b1;
      GTout <= 1'b0;
    end else if (load) begin
      cnt   <= nb_sat;
      LTout <= 1'b0;
      EQout <= 1'b1;
      GTout <= 1'b0;
    end else if (acc) begin
      cnt <= cnt - 4'd1;
      if (EQout) begin
        LTout <= a_lt;
        GTout <= a_gt;
        EQout <= !a_lt && !a_gt;
      end
    end
  end

`ifdef SIGNED_CMP_EN
  always_ff @(posedge clk) begin
    if (rst)       first <= 1'b0;
    else if (load) first <= 1'b1;
    else if (acc)  first <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cascade_compare_ctrl.sv
// Scoreboard bench for cascade_compare_ctrl: driver queues expected
// results, monitor checks them whenever done pulses.
module tb_cascade_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] num_bytes;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       busy;
  logic       done;
  logic       LTout;
  logic       EQout;
  logic       GTout;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;
`ifdef SIGNED_CMP_EN
  localparam logic [2:0] E_T2 = R_GT;
  localparam logic [2:0] E_T3 = R_LT;
`else
  localparam logic [2:0] E_T2 = R_LT;
  localparam logic [2:0] E_T3 = R_GT;
`endif

  cascade_compare_ctrl #(.MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_byte(a_byte), .b_byte(b_byte),
    .busy(busy), .done(done),
    .LTout(LTout), .EQout(EQout), .GTout(GTout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'({LTout, EQout, GTout}), int'(e.res));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", int'(busy), 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [3:0] nb);
    exp_t e;
    start     = 1'b1;
    num_bytes = nb;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (nb == 4'd0) begin
      e.res = R_EQ;
      e.cyc = cyc;
      q.push_back(e);
    end else begin
      chk("ready_run", int'(in_ready), 1);
      chk("busy_run", int'(busy), 1);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input bit last, input logic [2:0] res);
    exp_t e;
    in_valid = 1'b1;
    a_byte   = a;
    b_byte   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (last) begin
      e.res = res;
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, int'(in_ready), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_flags"}, int'({LTout, EQout, GTout}), int'(R_EQ));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_bytes = 4'd0;
    in_valid = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    idle(2);
    chk_reset("reset");
    rst = 1'b0;
    idle(1);

    start_op(4'd2);
    send(8'hC0, 8'hC0, 0, R_EQ);
    send(8'h00, 8'h00, 1, R_EQ);
    idle(1);

    start_op(4'd3);
    send(8'h40, 8'hC0, 0, R_EQ);
    send(8'hFF, 8'h00, 0, R_EQ);
    send(8'hFF, 8'h00, 1, E_T2);
    idle(1);

    start_op(4'd1);
    send(8'hF0, 8'h70, 1, E_T3);
    idle(1);

    start_op(4'd4);
    send(8'h50, 8'h50, 0, R_EQ);
    idle(2);
    send(8'h50, 8'h50, 0, R_EQ);
    send(8'h51, 8'h50, 0, R_EQ);
    idle(1);
    send(8'h00, 8'hFF, 1, R_GT);
    idle(3);
    chk("hold_flags", int'({LTout, EQout, GTout}), int'(R_GT));
    chk("idle_busy", int'(busy), 0);
    in_valid = 1'b1; a_byte = 8'h00; b_byte = 8'hFF;
    #1;
    chk("idle_ready", int'(in_ready), 0);
    idle(1);
    in_valid = 1'b0;
    chk("idle_ignore", int'({LTout, EQout, GTout}), int'(R_GT));

    start_op(4'd3);
    send(8'h10, 8'h10, 0, R_EQ);
    rst = 1'b1;
    idle(1);
    chk_reset("abort");
    rst = 1'b0;
    start_op(4'd1);
    send(8'h10, 8'h20, 1, R_LT);
    idle(1);

    start_op(4'd0);
    idle(1);
    chk("zero_idle_busy", int'(busy), 0);

    start_op(4'd12);
    send(8'h01, 8'h02, 0, R_EQ);
    start = 1'b1;
    num_bytes = 4'd1;
    idle(1);
    start = 1'b0;
    chk("start_ignored", int'(in_ready), 1);
    for (int i = 0; i < 6; i++)
      send(8'h02, 8'h01, 0, R_EQ);
    send(8'h00, 8'h00, 1, R_LT);
    idle(2);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      idle(1);
    chk("pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
